// File: rtl/tube_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tube_display_arbiter
// Description : Shares the 8-digit seven-segment tube display between the CPU
//               MMIO store path (cpu_*) and the debug monitor (dbg_*).
//               Grants are round-robin on ties. Each granted value owns the
//               display for at least HOLD_CYCLES cycles after its load.
// Ports       : clock, reset             - clock / sync active-high reset
//               cpu_req, cpu_data        - CPU request level and value
//               cpu_ack                  - 1-cycle pulse, cpu_data captured
//               dbg_req, dbg_data        - debug request level and value
//               dbg_ack                  - 1-cycle pulse, dbg_data captured
//               tube_load                - 1-cycle strobe to TubeDriver
//               tube_num                 - registered value to TubeDriver
//               owner                    - 00 none, 01 CPU, 10 debug
//               busy                     - 1 while in LOAD or HOLD
// Revision    : 1.0 - initial release
// ============================================================================
module tube_display_arbiter #(
   parameter int HOLD_CYCLES = 1000,
   parameter int DATA_W      = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_ack,
   input  logic              dbg_req,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              dbg_ack,
   output logic              tube_load,
   output logic [DATA_W-1:0] tube_num,
   output logic [1:0]        owner,
   output logic              busy
);

   localparam int         CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [1:0] OWN_NONE  = 2'b00;
   localparam logic [1:0] OWN_CPU   = 2'b01;
   localparam logic [1:0] OWN_DBG   = 2'b10;
   localparam logic       LAST_CPU  = 1'b0;
   localparam logic       LAST_DBG  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic             last;

   logic             pick_cpu;
   logic             owner_only;
   logic             grant;

   // Round-robin: on a tie the requester that was not granted last wins.
   assign pick_cpu = cpu_req & (~dbg_req | (last == LAST_DBG));

   // Only the current owner is asking: it may replace its own value mid-hold.
   assign owner_only = ((owner == OWN_CPU) & cpu_req & ~dbg_req) |
                       ((owner == OWN_DBG) & dbg_req & ~cpu_req);

   // At hold expiry arbitration runs straight into the next LOAD, so a
   // waiting requester does not lose an extra IDLE cycle.
   always_comb begin
      grant = 1'b0;
      case (state)
         IDLE:    grant = cpu_req | dbg_req;
         HOLD:    grant = (hold_cnt == '0) ? (cpu_req | dbg_req) : owner_only;
         default: grant = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         last      <= LAST_DBG;
         tube_num  <= '0;
         owner     <= OWN_NONE;
         tube_load <= 1'b0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         tube_load <= 1'b0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         if (grant) begin
            state     <= LOAD;
            busy      <= 1'b1;
            tube_load <= 1'b1;
            if (pick_cpu) begin
               tube_num <= cpu_data;
               owner    <= OWN_CPU;
               cpu_ack  <= 1'b1;
               last     <= LAST_CPU;
            end else begin
               tube_num <= dbg_data;
               owner    <= OWN_DBG;
               dbg_ack  <= 1'b1;
               last     <= LAST_DBG;
            end
         end else begin
            case (state)
               LOAD: begin
                  // Requests are not sampled here: the edge ending the ack
                  // cycle is when the winner drops its request.
                  state    <= HOLD;
                  hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
                  busy     <= 1'b1;
               end
               HOLD: begin
                  if (hold_cnt == '0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tube_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tube_display_arbiter
// Description : Self-checking bench for tube_display_arbiter (HOLD_CYCLES=4).
//               Cycle vectors hold inputs plus the outputs expected after the
//               edge; expected records go through a queue and are compared
//               one cycle later. A final hand-written tie sequence tracks
//               ack ordering and spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tube_display_arbiter;

   localparam int HOLD = 4;

   typedef struct {
      logic        rst;
      logic        creq;
      logic [31:0] cdata;
      logic        dreq;
      logic [31:0] ddata;
      logic        load;
      logic        cack;
      logic        dack;
      logic [31:0] num;
      logic [1:0]  own;
      logic        busy;
   } vec_t;

   typedef struct {
      logic [1:0]  own;
      logic [31:0] num;
   } ack_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_data = '0;
   logic        cpu_ack;
   logic        dbg_req = 1'b0;
   logic [31:0] dbg_data = '0;
   logic        dbg_ack;
   logic        tube_load;
   logic [31:0] tube_num;
   logic [1:0]  owner;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   vec_t tbl[$];
   vec_t exp_q[$];
   ack_t ack_q[$];

   tube_display_arbiter #(.HOLD_CYCLES(HOLD), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
      .dbg_req(dbg_req), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
      .tube_load(tube_load), .tube_num(tube_num), .owner(owner), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic add(input logic rst, input logic creq, input logic [31:0] cdata,
                      input logic dreq, input logic [31:0] ddata,
                      input logic load, input logic cack, input logic dack,
                      input logic [31:0] num, input logic [1:0] own, input logic bsy);
      vec_t v;
      v.rst = rst; v.creq = creq; v.cdata = cdata; v.dreq = dreq; v.ddata = ddata;
      v.load = load; v.cack = cack; v.dack = dack; v.num = num; v.own = own; v.busy = bsy;
      tbl.push_back(v);
   endtask

   task automatic addn(input int n, input logic creq, input logic [31:0] cdata,
                       input logic dreq, input logic [31:0] ddata,
                       input logic [31:0] num, input logic [1:0] own, input logic bsy);
      for (int i = 0; i < n; i++) add(0, creq, cdata, dreq, ddata, 0, 0, 0, num, own, bsy);
   endtask

   initial begin
      int  t_cpu, t_dbg;
      bit  seen_cpu, seen_dbg;
      vec_t e;
      ack_t a;

      // 1. reset two cycles, then idle
      add(1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 0);
      add(1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 0);
      add(0, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 0);
      // 2. single CPU request: LOAD + 4 HOLD, then idle keeps the value
      add(0, 1, 32'h12345678, 0, 0,  1, 1, 0, 32'h12345678, 2'b01, 1);
      addn(4, 0, 0, 0, 0, 32'h12345678, 2'b01, 1);
      addn(2, 0, 0, 0, 0, 32'h12345678, 2'b01, 0);
      // 3. tie from reset: CPU first, debug 5 cycles later at hold expiry
      add(1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 0);
      add(0, 1, 32'hAAAA0000, 1, 32'h0000BBBB,  1, 1, 0, 32'hAAAA0000, 2'b01, 1);
      addn(4, 0, 0, 1, 32'h0000BBBB, 32'hAAAA0000, 2'b01, 1);
      add(0, 0, 0, 1, 32'h0000BBBB,  1, 0, 1, 32'h0000BBBB, 2'b10, 1);
      addn(4, 0, 0, 0, 0, 32'h0000BBBB, 2'b10, 1);
      addn(1, 0, 0, 0, 0, 32'h0000BBBB, 2'b10, 0);
      // 4. CPU owner update in hold cycle 2 restarts the hold
      add(0, 1, 32'h11110000, 0, 0,  1, 1, 0, 32'h11110000, 2'b01, 1);
      addn(2, 0, 0, 0, 0, 32'h11110000, 2'b01, 1);
      add(0, 1, 32'h00000001, 0, 0,  1, 1, 0, 32'h00000001, 2'b01, 1);
      addn(4, 0, 0, 0, 0, 32'h00000001, 2'b01, 1);
      addn(1, 0, 0, 0, 0, 32'h00000001, 2'b01, 0);
      // 5. CPU owns, debug pending, CPU re-requests: debug then CPU
      add(0, 1, 32'h22220000, 0, 0,  1, 1, 0, 32'h22220000, 2'b01, 1);
      add(0, 0, 0, 1, 32'h33330000,  0, 0, 0, 32'h22220000, 2'b01, 1);
      addn(3, 1, 32'h22220001, 1, 32'h33330000, 32'h22220000, 2'b01, 1);
      add(0, 1, 32'h22220001, 1, 32'h33330000,  1, 0, 1, 32'h33330000, 2'b10, 1);
      addn(4, 1, 32'h22220001, 0, 0, 32'h33330000, 2'b10, 1);
      add(0, 1, 32'h22220001, 0, 0,  1, 1, 0, 32'h22220001, 2'b01, 1);
      add(0, 0, 0, 0, 0,  0, 0, 0, 32'h22220001, 2'b01, 1);
      // 6. reset in hold cycle 1 with debug pending: aborted, debug next
      add(1, 0, 0, 1, 32'h44440000,  0, 0, 0, 0, 2'b00, 0);
      add(0, 0, 0, 1, 32'h44440000,  1, 0, 1, 32'h44440000, 2'b10, 1);
      addn(4, 0, 0, 0, 0, 32'h44440000, 2'b10, 1);
      addn(1, 0, 0, 0, 0, 32'h44440000, 2'b10, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clock);
         reset    = tbl[i].rst;
         cpu_req  = tbl[i].creq;
         cpu_data = tbl[i].cdata;
         dbg_req  = tbl[i].dreq;
         dbg_data = tbl[i].ddata;
         exp_q.push_back(tbl[i]);
         @(posedge clock);
         #1;
         e = exp_q.pop_front();
         vectors++;
         if (tube_load !== e.load || cpu_ack !== e.cack || dbg_ack !== e.dack ||
             tube_num !== e.num || owner !== e.own || busy !== e.busy) begin
            miscompares++;
            $display("FAIL vec%0d got load=%b cack=%b dack=%b num=%h own=%b busy=%b exp load=%b cack=%b dack=%b num=%h own=%b busy=%b",
                     i, tube_load, cpu_ack, dbg_ack, tube_num, owner, busy,
                     e.load, e.cack, e.dack, e.num, e.own, e.busy);
         end
      end

      // Tie after a debug grant (last=DBG): CPU first, debug exactly 5 later.
      @(negedge clock);
      cpu_req = 1'b1; cpu_data = 32'h55550000;
      dbg_req = 1'b1; dbg_data = 32'h66660000;
      a.own = 2'b01; a.num = 32'h55550000; ack_q.push_back(a);
      a.own = 2'b10; a.num = 32'h66660000; ack_q.push_back(a);
      seen_cpu = 0; seen_dbg = 0; t_cpu = 0; t_dbg = 0;
      for (int c = 0; c < 40 && !(seen_cpu && seen_dbg); c++) begin
         @(posedge clock);
         #1;
         if (cpu_ack || dbg_ack) begin
            vectors++;
            if (ack_q.size() == 0) begin
               miscompares++;
               $display("FAIL tie_extra_ack got cack=%b dack=%b exp no ack", cpu_ack, dbg_ack);
            end else begin
               a = ack_q.pop_front();
               if (owner !== a.own || tube_num !== a.num || (cpu_ack && dbg_ack)) begin
                  miscompares++;
                  $display("FAIL tie_ack got own=%b num=%h cack=%b dack=%b exp own=%b num=%h",
                           owner, tube_num, cpu_ack, dbg_ack, a.own, a.num);
               end
            end
            if (cpu_ack) begin cpu_req = 1'b0; seen_cpu = 1; t_cpu = c; end
            if (dbg_ack) begin dbg_req = 1'b0; seen_dbg = 1; t_dbg = c; end
         end
      end
      vectors++;
      if (!(seen_cpu && seen_dbg)) begin
         miscompares++;
         $display("FAIL tie_timeout got cpu_seen=%0d dbg_seen=%0d exp both acked", seen_cpu, seen_dbg);
      end else if (t_dbg - t_cpu != 5) begin
         miscompares++;
         $display("FAIL tie_spacing got %0d cycles exp 5", t_dbg - t_cpu);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
